// File: rtl/mem_stage.sv
// Memory-access stage: drives a multi-cycle req/ack data memory from EX/MEM,
// stalls the front of the pipe until the access completes, and registers the
// MEM/WB write-back outputs. Halts on dump, misaligned access or memory timeout.
module mem_stage #(
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] result_in,
   input  logic [DATA_W-1:0] B_in,
   input  logic              mem_write_in,
   input  logic              mem_to_reg_in,
   input  logic              reg_write_in,
   input  logic [2:0]        reg_wr_sel_in,
   input  logic              dump_in,
   output logic              mem_req,
   output logic              mem_wr,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic              stall,
   output logic [DATA_W-1:0] wb_data_out,
   output logic [2:0]        reg_wr_sel_out,
   output logic              reg_write_out,
   output logic              halt_out,
   output logic              err_align,
   output logic              err_timeout
);

   localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

   typedef enum logic [1:0] {StIdle, StBusy, StHalted} state_e;

   state_e            state_q;
   logic [CntW-1:0]   cnt_q;

   // Request fields captured when a multi-cycle access starts
   logic [DATA_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              wr_q;
   logic              m2r_q;
   logic              regw_q;
   logic [2:0]        sel_q;

   // MEM/WB registers and sticky status
   logic [DATA_W-1:0] wb_data_q;
   logic [2:0]        wb_sel_q;
   logic              wb_regw_q;
   logic              halt_q;
   logic              err_align_q;
   logic              err_timeout_q;

   logic access;
   logic mis;
   logic start;
   logic busy;

   // Request decode and combinational memory/stall outputs
   always_comb begin
      access    = mem_write_in | mem_to_reg_in;
      mis       = access & result_in[0];
      start     = (state_q == StIdle) & access & ~mis & ~dump_in;
      busy      = (state_q == StBusy);
      mem_req   = start | busy;
      mem_wr    = busy ? wr_q    : mem_write_in;
      mem_addr  = busy ? addr_q  : result_in;
      mem_wdata = busy ? wdata_q : B_in;
      stall     = mem_req & ~mem_ack;
   end

   // FSM, request latch, timeout counter and registered MEM/WB outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= StIdle;
         cnt_q         <= '0;
         addr_q        <= '0;
         wdata_q       <= '0;
         wr_q          <= 1'b0;
         m2r_q         <= 1'b0;
         regw_q        <= 1'b0;
         sel_q         <= '0;
         wb_data_q     <= '0;
         wb_sel_q      <= '0;
         wb_regw_q     <= 1'b0;
         halt_q        <= 1'b0;
         err_align_q   <= 1'b0;
         err_timeout_q <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (dump_in) begin
                  // Dump wins over any access in the same instruction
                  wb_regw_q <= 1'b0;
                  halt_q    <= 1'b1;
                  state_q   <= StHalted;
               end else if (mis) begin
                  wb_regw_q   <= 1'b0;
                  err_align_q <= 1'b1;
                  halt_q      <= 1'b1;
                  state_q     <= StHalted;
               end else if (access) begin
                  addr_q  <= result_in;
                  wdata_q <= B_in;
                  wr_q    <= mem_write_in;
                  m2r_q   <= mem_to_reg_in;
                  regw_q  <= reg_write_in;
                  sel_q   <= reg_wr_sel_in;
                  if (mem_ack) begin
                     // Zero-stall completion
                     wb_data_q <= mem_to_reg_in ? mem_rdata : result_in;
                     wb_sel_q  <= reg_wr_sel_in;
                     wb_regw_q <= reg_write_in;
                  end else begin
                     wb_regw_q <= 1'b0;
                     cnt_q     <= '0;
                     state_q   <= StBusy;
                  end
               end else begin
                  wb_data_q <= result_in;
                  wb_sel_q  <= reg_wr_sel_in;
                  wb_regw_q <= reg_write_in;
               end
            end
            StBusy: begin
               if (mem_ack) begin
                  wb_data_q <= m2r_q ? mem_rdata : addr_q;
                  wb_sel_q  <= sel_q;
                  wb_regw_q <= regw_q;
                  state_q   <= StIdle;
               end else begin
                  wb_regw_q <= 1'b0;
                  if (cnt_q == CntLast) begin
                     err_timeout_q <= 1'b1;
                     halt_q        <= 1'b1;
                     state_q       <= StHalted;
                  end else begin
                     cnt_q <= cnt_q + CntW'(1);
                  end
               end
            end
            StHalted: begin
               wb_regw_q <= 1'b0;
            end
            default: begin
               wb_regw_q <= 1'b0;
               state_q   <= StHalted;
            end
         endcase
      end
   end

   assign wb_data_out    = wb_data_q;
   assign reg_wr_sel_out = wb_sel_q;
   assign reg_write_out  = wb_regw_q;
   assign halt_out       = halt_q;
   assign err_align      = err_align_q;
   assign err_timeout    = err_timeout_q;

endmodule
